// File: rtl/imem_program_encoder_if.sv
// Symbolic-instruction stream into the imem program encoder.
// The producer drives a mnemonic code plus raw fields; the encoder answers with ready.
interface imem_program_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;

    modport master (
        output in_valid,
        output in_mnem,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_mnem,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_imm,
        output in_ready
    );
endinterface

// File: rtl/imem_program_encoder.sv
// Packs symbolic instructions into 32-bit machine words (same op/funct map as the
// decoder, custom extensions included) and writes them sequentially into imem.
module imem_program_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int BASE   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   finish,
    imem_program_encoder_if.slave  instr,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [31:0]            imem_wd,
    output logic [ADDR_W:0]        count,
    output logic                   prog_done,
    output logic                   err
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;

    logic [25:0] r_fields;
    logic [25:0] i_fields;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        last_write;

    assign r_fields = {6'b000000, instr.in_rs, instr.in_rt, instr.in_rd, 5'b00000};
    assign i_fields = {instr.in_rs, instr.in_rt, instr.in_imm[15:0]};

    // Mnemonic table shared with the main/ALU control decoder.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (instr.in_mnem)
            5'd0:    word = {r_fields, 6'b100000};
            5'd1:    word = {r_fields, 6'b100010};
            5'd2:    word = {r_fields, 6'b100100};
            5'd3:    word = {r_fields, 6'b100101};
            5'd4:    word = {r_fields, 6'b101010};
            5'd5:    word = {r_fields, 6'b010010};
            5'd6:    word = {r_fields, 6'b010011};
            5'd7:    word = {r_fields, 6'b101011};
            5'd8:    word = {r_fields, 6'b001001};
            5'd9:    word = {6'b100011, i_fields};
            5'd10:   word = {6'b101011, i_fields};
            5'd11:   word = {6'b000100, i_fields};
            5'd12:   word = {6'b001000, i_fields};
            5'd13:   word = {6'b001100, i_fields};
            5'd14:   word = {6'b111101, i_fields};
            5'd15:   word = {6'b111100, i_fields};
            5'd16:   word = {6'b000010, instr.in_imm};
            5'd17:   word = 32'hF800_0000;
            default: legal = 1'b0;
        endcase
    end

    assign instr.in_ready = (state == LOAD) && (count < DEPTH_C);
    assign accept         = instr.in_valid && instr.in_ready;
    assign last_write     = accept && legal && (count == LAST_C);

    // Illegal mnemonics are consumed but only flag err; the write slot is not used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= BASE_C;
            count     <= '0;
            err       <= 1'b0;
            prog_done <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= BASE_C;
            imem_wd   <= 32'h0000_0000;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        addr      <= BASE_C;
                        count     <= '0;
                        err       <= 1'b0;
                        prog_done <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            imem_we   <= 1'b1;
                            imem_addr <= addr;
                            imem_wd   <= word;
                            count     <= count + 1'b1;
                            if (!last_write) begin
                                addr <= addr + 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    // prog_done rises together with the final write it closes.
                    if (finish || last_write) begin
                        state     <= DONE;
                        prog_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Directed bench for imem_program_encoder with hand-computed instruction words.
module tb_imem_program_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        finish;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic [6:0]  count;
    logic        prog_done;
    logic        err;

    int check_count = 0;
    int fail_count  = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_program_encoder_if bus ();

    imem_program_encoder #(
        .ADDR_W(6),
        .DEPTH (4),
        .BASE  (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .finish   (finish),
        .instr    (bus),
        .imem_we  (imem_we),
        .imem_addr(imem_addr),
        .imem_wd  (imem_wd),
        .count    (count),
        .prog_done(prog_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Acts as the instruction memory: records every write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wd);
        end
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic v, input logic [4:0] m, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [25:0] imm,
                       input logic s, input logic f);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_mnem  = m;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
        start        = s;
        finish       = f;
        @(posedge clk);
        #1;
    endtask

    task idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        finish       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mnem  = 5'd0;
        bus.in_rs    = 5'd0;
        bus.in_rt    = 5'd0;
        bus.in_rd    = 5'd0;
        bus.in_imm   = 26'd0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_we",    32'(imem_we),      32'd0);
        checkOutput("rst_addr",  32'(imem_addr),    32'd0);
        checkOutput("rst_wd",    imem_wd,           32'd0);
        checkOutput("rst_count", 32'(count),        32'd0);
        checkOutput("rst_done",  32'(prog_done),    32'd0);
        checkOutput("rst_err",   32'(err),          32'd0);
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // IDLE ignores traffic
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b0);
        checkOutput("idle_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("idle_we",    32'(imem_we),      32'd0);

        // T1: ADD 1,2,3
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        checkOutput("t1_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b0);
        checkOutput("t1_we",    32'(imem_we),   32'd1);
        checkOutput("t1_addr",  32'(imem_addr), 32'd0);
        checkOutput("t1_wd",    imem_wd,        32'h0022_1820);
        checkOutput("t1_count", 32'(count),     32'd1);
        idleCycle();
        checkOutput("t1_we_one", 32'(imem_we), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b1);
        checkOutput("t1_done",  32'(prog_done),    32'd1);
        checkOutput("t1_ready_off", 32'(bus.in_ready), 32'd0);

        // T2: LW then J back-to-back; start inside LOAD is ignored
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        checkOutput("t2_done_clr", 32'(prog_done), 32'd0);
        applyStimulus(1'b1, 5'd9, 5'd0, 5'd2, 5'd0, 26'd8, 1'b0, 1'b0);
        checkOutput("t2_lw_we",   32'(imem_we),   32'd1);
        checkOutput("t2_lw_addr", 32'(imem_addr), 32'd0);
        checkOutput("t2_lw_wd",   imem_wd,        32'h8C02_0008);
        applyStimulus(1'b1, 5'd16, 5'd0, 5'd0, 5'd0, 26'h10, 1'b1, 1'b0);
        checkOutput("t2_j_we",   32'(imem_we),   32'd1);
        checkOutput("t2_j_addr", 32'(imem_addr), 32'd1);
        checkOutput("t2_j_wd",   imem_wd,        32'h0800_0010);
        checkOutput("t2_count",  32'(count),     32'd2);
        idleCycle();
        checkOutput("t2_count_hold", 32'(count), 32'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b1);

        // T3: PUSH, NOP, illegal code 20
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd15, 5'd29, 5'd5, 5'd0, 26'd0, 1'b0, 1'b0);
        checkOutput("t3_push_addr", 32'(imem_addr), 32'd0);
        checkOutput("t3_push_wd",   imem_wd,        32'hF3A5_0000);
        applyStimulus(1'b1, 5'd17, 5'd31, 5'd31, 5'd31, 26'h3FF_FFFF, 1'b0, 1'b0);
        checkOutput("t3_nop_addr", 32'(imem_addr), 32'd1);
        checkOutput("t3_nop_wd",   imem_wd,        32'hF800_0000);
        applyStimulus(1'b1, 5'd20, 5'd1, 5'd2, 5'd3, 26'd4, 1'b0, 1'b0);
        checkOutput("t3_ill_we",    32'(imem_we),      32'd0);
        checkOutput("t3_ill_err",   32'(err),          32'd1);
        checkOutput("t3_ill_count", 32'(count),        32'd2);
        checkOutput("t3_ill_ready", 32'(bus.in_ready), 32'd1);
        idleCycle();
        checkOutput("t3_err_sticky", 32'(err), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b1);

        // T4: six ADDI words held valid into a 4-deep memory
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        checkOutput("t4_err_clr", 32'(err), 32'd0);
        wr_addr.delete();
        wr_data.delete();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 5'd12, 5'd1, 5'd1, 5'd0, 26'(k), 1'b0, 1'b0);
            if (k == 4) begin
                checkOutput("t4_ready_full", 32'(bus.in_ready), 32'd0);
                checkOutput("t4_done_full",  32'(prog_done),    32'd1);
            end
        end
        idleCycle();
        checkOutput("t4_nwrites", 32'(wr_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < wr_data.size(); k++) begin
            checkOutput($sformatf("t4_addr%0d", k), 32'(wr_addr[k]), 32'(k));
            checkOutput($sformatf("t4_wd%0d", k),   wr_data[k],      32'h2021_0001 + 32'(k));
        end
        checkOutput("t4_count", 32'(count),     32'd4);
        checkOutput("t4_err",   32'(err),       32'd0);
        checkOutput("t4_done",  32'(prog_done), 32'd1);

        // T5: reset lands while an accepted word is being presented
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b0);
        wr_addr.delete();
        wr_data.delete();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("t5_we",    32'(imem_we),      32'd0);
        checkOutput("t5_addr",  32'(imem_addr),    32'd0);
        checkOutput("t5_wd",    imem_wd,           32'd0);
        checkOutput("t5_count", 32'(count),        32'd0);
        checkOutput("t5_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("t5_nowrite", 32'(wr_data.size()), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd2, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0, 1'b0);
        checkOutput("t5_and_addr", 32'(imem_addr), 32'd0);
        checkOutput("t5_and_wd",   imem_wd,        32'h00E8_4824);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b1);

        // T6: finish coincides with an accepted SUB rs=5 rt=6 rd=6
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 5'd6, 26'd0, 1'b0, 1'b1);
        checkOutput("t6_we",    32'(imem_we),      32'd1);
        checkOutput("t6_addr",  32'(imem_addr),    32'd0);
        checkOutput("t6_wd",    imem_wd,           32'h00A6_3022);
        checkOutput("t6_done",  32'(prog_done),    32'd1);
        checkOutput("t6_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b1);
        checkOutput("t6_ign_we",    32'(imem_we), 32'd0);
        checkOutput("t6_ign_count", 32'(count),   32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);
        checkOutput("sf_done_start",  32'(prog_done),    32'd0);
        checkOutput("sf_ready_start", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);
        checkOutput("sf_done_load",  32'(prog_done), 32'd1);
        checkOutput("sf_count_load", 32'(count),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
